// File: rtl/r8b_mbe_pipe.sv
// -----------------------------------------------------------------------------
// r8b_mbe_pipe -- pipelined radix-8 modified-Booth multiplier
//
// Computes Z = X*Y (2N bits, exact) for unsigned (TC=0) or two's-complement
// (TC=1) operands. Y is recoded into radix-8 Booth digits in -4..+4. Each digit
// selects one of +/-{0, X, 2X, 3X, 4X}, where 3X is precomputed once per
// operation. The partial products are compressed with a carry-save tree to a
// sum/carry pair. One carry-propagate add then resolves that pair.
//
// Pipeline (PIPE_STAGES register stages from accepted operands to Z):
//   1: recode + 3X + tree + add all in one stage
//   2: [recode + 3X] | [tree + add]
//   3: [recode + 3X] | [tree] | [add]
//   4: [recode + 3X] | [tree, low digits] | [tree, high digits] | [add]
// The whole pipeline advances together whenever I_READY is high, and every
// stage carries its own valid bit.
//
// Optional feature: define R8B_MBE_ACC_EN to add the ACC input. The result
// register then becomes an accumulator A:
//   A = ACC ? A + X*Y : X*Y   (modulo 2^(2N)), Z = A.
//
// Parameters:
//   N            operand width, 6..64
//   PIPE_STAGES  register stages, 1..4
// Ports:
//   CLK      clock, rising edge
//   RST_n    asynchronous active-low reset
//   I_VALID  operands valid          I_READY  operands accepted this cycle
//   X, Y     multiplicand/multiplier TC       1 = signed operands
//   ACC      accumulate (R8B_MBE_ACC_EN only)
//   O_VALID  Z valid                 O_READY  downstream takes Z
//   Z        2N-bit product / accumulator
// -----------------------------------------------------------------------------
module r8b_mbe_pipe #(
  parameter int N           = 24,
  parameter int PIPE_STAGES = 3
) (
  input  logic           CLK,
  input  logic           RST_n,
  input  logic           I_VALID,
  output logic           I_READY,
  input  logic [N-1:0]   X,
  input  logic [N-1:0]   Y,
  input  logic           TC,
`ifdef R8B_MBE_ACC_EN
  input  logic           ACC,
`endif
  output logic           O_VALID,
  input  logic           O_READY,
  output logic [2*N-1:0] Z
);

  localparam int W    = 2 * N;
  // Y is extended by one bit, then padded up to a multiple of 3.
  localparam int D    = (N + 3) / 3;
  localparam int YW   = 3 * D;
  localparam int HALF = D / 2;

  typedef logic [W-1:0] word_t;

  typedef struct packed {
`ifdef R8B_MBE_ACC_EN
    logic            acc;
`endif
    word_t           xe;    // X extended to 2N bits (sign or zero)
    word_t           x3;    // 3X, computed once per operation
    logic [D-1:0][3:0] dig; // Booth digits, two's complement, -4..+4
  } rec_t;

  typedef struct packed {
    word_t s;
    word_t c;
  } sc_t;

  typedef struct packed {
    rec_t rec;
    sc_t  sc;
  } part_t;

  typedef struct packed {
`ifdef R8B_MBE_ACC_EN
    logic acc;
`endif
    sc_t  sc;
  } red_t;

  function automatic rec_t recode(input logic [N-1:0] x, input logic [N-1:0] y,
                                  input logic tc);
    rec_t        r;
    logic [YW:0] yx;
    int          d;
    r    = '0;
    r.xe = {{N{tc & x[N-1]}}, x};
    r.x3 = r.xe + (r.xe << 1);
    // The implicit y[-1] = 0 sits at yx[0], so window i is yx[3i+3:3i].
    yx   = {{(YW-N){tc & y[N-1]}}, y, 1'b0};
    for (int i = 0; i < D; i++) begin
      d = (yx[3*i+3] ? -4 : 0) + (yx[3*i+2] ? 2 : 0)
        + (yx[3*i+1] ? 1 : 0)  + (yx[3*i]   ? 1 : 0);
      r.dig[i] = 4'(d);
    end
    return r;
  endfunction

  // Carry-save accumulation of the partial products for digits lo..hi-1.
  function automatic sc_t compress(input rec_t r, input sc_t in,
                                   input int lo, input int hi);
    sc_t        o;
    word_t      m;
    word_t      pp;
    word_t      t;
    logic [3:0] mag;
    o = in;
    for (int i = 0; i < D; i++) begin
      if (i >= lo && i < hi) begin
        mag = r.dig[i][3] ? -r.dig[i] : r.dig[i];
        case (mag)
          4'd0:    m = '0;
          4'd1:    m = r.xe;
          4'd2:    m = r.xe << 1;
          4'd3:    m = r.x3;
          default: m = r.xe << 2;
        endcase
        pp  = r.dig[i][3] ? -m : m;
        pp  = pp << (3 * i);
        t   = o.s ^ o.c ^ pp;
        o.c = ((o.s & o.c) | (o.s & pp) | (o.c & pp)) << 1;
        o.s = t;
      end
    end
    return o;
  endfunction

  logic  adv;
  logic  o_valid_q, o_valid_d;
  word_t z_q, z_d;

  assign I_READY = !o_valid_q || O_READY;
  assign adv     = I_READY;
  assign O_VALID = o_valid_q;
  assign Z       = z_q;

  // ---------------------------------------------------------------- stage 1
  rec_t rec_c, rec_s;
  logic rec_v;

  always_comb begin
    rec_c = recode(X, Y, TC);
`ifdef R8B_MBE_ACC_EN
    rec_c.acc = ACC;
`endif
  end

  if (PIPE_STAGES >= 2) begin : g_rec_reg
    rec_t rec_q, rec_d;
    logic rec_v_q, rec_v_d;

    // NOTE: every variable in an always_comb gets a value on every path
    // (here through the ternaries). Otherwise a latch is inferred.
    always_comb begin
      rec_d   = adv ? rec_c   : rec_q;
      rec_v_d = adv ? I_VALID : rec_v_q;
    end

    // NOTE: sequential state uses non-blocking assignments only. This keeps
    // the flop updates order-independent across always_ff blocks.
    always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) rec_v_q <= 1'b0;
      else        rec_v_q <= rec_v_d;
    end

    // NOTE: datapath payload registers have no reset. The valid bits alone
    // decide whether their contents mean anything.
    always_ff @(posedge CLK) rec_q <= rec_d;

    assign rec_s = rec_q;
    assign rec_v = rec_v_q;
  end else begin : g_rec_comb
    assign rec_s = rec_c;
    assign rec_v = I_VALID;
  end

  // ------------------------------------------- compression tree, low digits
  part_t part_c, part_s;
  logic  part_v;

  always_comb begin
    part_c.rec = rec_s;
    part_c.sc  = compress(rec_s, '0, 0, HALF);
  end

  if (PIPE_STAGES == 4) begin : g_part_reg
    part_t part_q, part_d;
    logic  part_v_q, part_v_d;

    always_comb begin
      part_d   = adv ? part_c : part_q;
      part_v_d = adv ? rec_v  : part_v_q;
    end

    always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) part_v_q <= 1'b0;
      else        part_v_q <= part_v_d;
    end

    always_ff @(posedge CLK) part_q <= part_d;

    assign part_s = part_q;
    assign part_v = part_v_q;
  end else begin : g_part_comb
    assign part_s = part_c;
    assign part_v = rec_v;
  end

  // ------------------------------------------ compression tree, high digits
  red_t red_c, red_s;
  logic red_v;

  always_comb begin
    red_c.sc = compress(part_s.rec, part_s.sc, HALF, D);
`ifdef R8B_MBE_ACC_EN
    red_c.acc = part_s.rec.acc;
`endif
  end

  if (PIPE_STAGES >= 3) begin : g_red_reg
    red_t red_q, red_d;
    logic red_v_q, red_v_d;

    always_comb begin
      red_d   = adv ? red_c  : red_q;
      red_v_d = adv ? part_v : red_v_q;
    end

    always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) red_v_q <= 1'b0;
      else        red_v_q <= red_v_d;
    end

    always_ff @(posedge CLK) red_q <= red_d;

    assign red_s = red_q;
    assign red_v = red_v_q;
  end else begin : g_red_comb
    assign red_s = red_c;
    assign red_v = part_v;
  end

  // ------------------------------------------- final carry-propagate add
  word_t sum;
  word_t result;

  always_comb begin
    sum    = red_s.sc.s + red_s.sc.c;
`ifdef R8B_MBE_ACC_EN
    result = red_s.acc ? z_q + sum : sum;
`else
    result = sum;
`endif
    // Z only loads on a valid result. Bubbles leave the last value in place.
    z_d       = (adv && red_v) ? result : z_q;
    o_valid_d = adv ? red_v : o_valid_q;
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      z_q       <= '0;
      o_valid_q <= 1'b0;
    end else begin
      z_q       <= z_d;
      o_valid_q <= o_valid_d;
    end
  end

endmodule

// File: tb/tb_r8b_mbe_pipe.sv
// -----------------------------------------------------------------------------
// tb_r8b_mbe_pipe -- directed self-checking bench for r8b_mbe_pipe
// (N=24, PIPE_STAGES=3). Inputs are driven just after each falling edge.
// Outputs are observed 1 ns later, well away from the rising edge. Each step
// below corresponds to one clock cycle.
// -----------------------------------------------------------------------------
module tb_r8b_mbe_pipe;

  localparam int N = 24;
  localparam int W = 2 * N;

  logic         CLK = 1'b0;
  logic         RST_n;
  logic         I_VALID;
  logic         I_READY;
  logic [N-1:0] X;
  logic [N-1:0] Y;
  logic         TC;
  logic         ACC;
  logic         O_VALID;
  logic         O_READY;
  logic [W-1:0] Z;

  int tests = 0;
  int fails = 0;

  logic [W-1:0] q[$];
  logic [31:0]  r;

  // Directed operand set with hand-computed products.
  logic [N-1:0] vx  [8] = '{24'hFFFFFF, 24'hFFFFFF, 24'h800000, 24'hFFFFFD,
                            24'h123456, 24'hFFFFFF, 24'hFFFFFF, 24'h7FFFFF};
  logic [N-1:0] vy  [8] = '{24'hFFFFFF, 24'hFFFFFF, 24'h800000, 24'h000007,
                            24'h000100, 24'h800000, 24'h800000, 24'h7FFFFF};
  logic         vtc [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  logic [W-1:0] vz  [8] = '{48'hFFFFFE000001, 48'h000000000001,
                            48'h400000000000, 48'hFFFFFFFFFFEB,
                            48'h000012345600, 48'h000000800000,
                            48'h7FFFFF800000, 48'h3FFFFF000001};

  always #5 CLK = ~CLK;

  r8b_mbe_pipe #(.N(N), .PIPE_STAGES(3)) dut (
    .CLK     (CLK),
    .RST_n   (RST_n),
    .I_VALID (I_VALID),
    .I_READY (I_READY),
    .X       (X),
    .Y       (Y),
    .TC      (TC),
`ifdef R8B_MBE_ACC_EN
    .ACC     (ACC),
`endif
    .O_VALID (O_VALID),
    .O_READY (O_READY),
    .Z       (Z)
  );

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [N-1:0] x, input logic [N-1:0] y,
                       input logic tc, input logic ordy);
    I_VALID = iv;
    X       = x;
    Y       = y;
    TC      = tc;
    O_READY = ordy;
    #1;
  endtask

  function automatic logic [W-1:0] model(input logic [N-1:0] x, input logic [N-1:0] y,
                                         input logic tc);
    logic [W-1:0] xe;
    logic [W-1:0] ye;
    xe = {{N{tc & x[N-1]}}, x};
    ye = {{N{tc & y[N-1]}}, y};
    return xe * ye;
  endfunction

  initial begin
    ACC   = 1'b0;
    RST_n = 1'b0;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    check_bit("rst_o_valid", O_VALID, 1'b0);
    check    ("rst_z", Z, 48'd0);
    check_bit("rst_i_ready", I_READY, 1'b1);
    @(negedge CLK);
    @(negedge CLK);
    RST_n = 1'b1;
    @(negedge CLK);

    // Basic latency: 3*5 accepted in cycle 0, so the result appears in cycle 3.
    drive(1'b1, 24'd3, 24'd5, 1'b0, 1'b1);
    check_bit("lat_accept", I_READY, 1'b1);
    @(negedge CLK);
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    check_bit("lat_c1_o_valid", O_VALID, 1'b0);
    @(negedge CLK);
    check_bit("lat_c2_o_valid", O_VALID, 1'b0);
    @(negedge CLK);
    check_bit("lat_c3_o_valid", O_VALID, 1'b1);
    check    ("lat_c3_z", Z, 48'd15);
    @(negedge CLK);
    check_bit("hold_o_valid", O_VALID, 1'b0);
    check    ("hold_z", Z, 48'd15);
    @(negedge CLK);

    // Corner operands, back to back at full throughput.
    for (int k = 0; k < 11; k++) begin
      if (k < 8) drive(1'b1, vx[k], vy[k], vtc[k], 1'b1);
      else       drive(1'b0, '0, '0, 1'b0, 1'b1);
      if (k >= 3) begin
        check_bit($sformatf("corner%0d_o_valid", k - 3), O_VALID, 1'b1);
        check    ($sformatf("corner%0d_z", k - 3), Z, vz[k-3]);
      end
      @(negedge CLK);
    end
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    check_bit("corner_drained", O_VALID, 1'b0);
    @(negedge CLK);

    // Backpressure: O_READY=0 for cycles 3..6 while 8*9 waits at the input.
    drive(1'b1, 24'd2, 24'd3, 1'b0, 1'b1);
    @(negedge CLK);
    drive(1'b1, 24'd4, 24'd5, 1'b0, 1'b1);
    @(negedge CLK);
    drive(1'b1, 24'd6, 24'd7, 1'b0, 1'b1);
    @(negedge CLK);
    for (int k = 3; k <= 6; k++) begin
      drive(1'b1, 24'd8, 24'd9, 1'b0, 1'b0);
      check_bit($sformatf("stall_c%0d_i_ready", k), I_READY, 1'b0);
      check_bit($sformatf("stall_c%0d_o_valid", k), O_VALID, 1'b1);
      check    ($sformatf("stall_c%0d_z", k), Z, 48'd6);
      @(negedge CLK);
    end
    drive(1'b1, 24'd8, 24'd9, 1'b0, 1'b1);
    check_bit("stall_c7_i_ready", I_READY, 1'b1);
    check    ("stall_c7_z", Z, 48'd6);
    @(negedge CLK);
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    check_bit("stall_c8_o_valid", O_VALID, 1'b1);
    check    ("stall_c8_z", Z, 48'd20);
    @(negedge CLK);
    check_bit("stall_c9_o_valid", O_VALID, 1'b1);
    check    ("stall_c9_z", Z, 48'd42);
    @(negedge CLK);
    check_bit("stall_c10_o_valid", O_VALID, 1'b1);
    check    ("stall_c10_z", Z, 48'd72);
    @(negedge CLK);
    check_bit("stall_c11_o_valid", O_VALID, 1'b0);
    check    ("stall_c11_z", Z, 48'd72);
    @(negedge CLK);

    // Reset with two operations in flight.
    drive(1'b1, 24'd5, 24'd5, 1'b0, 1'b1);
    @(negedge CLK);
    drive(1'b1, 24'd7, 24'd7, 1'b0, 1'b1);
    @(negedge CLK);
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    check("inflight_z_before", Z, 48'd72);
    RST_n = 1'b0;
    #1;
    check_bit("midrst_o_valid", O_VALID, 1'b0);
    check    ("midrst_z", Z, 48'd0);
    check_bit("midrst_i_ready", I_READY, 1'b1);
    @(negedge CLK);
    RST_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      drive(1'b0, '0, '0, 1'b0, 1'b1);
      check_bit($sformatf("postrst_c%0d_o_valid", k), O_VALID, 1'b0);
      @(negedge CLK);
    end

`ifdef R8B_MBE_ACC_EN
    // Accumulate: 10*10, then +(-1*1), then +(2*3).
    ACC = 1'b0;
    drive(1'b1, 24'd10, 24'd10, 1'b0, 1'b1);
    @(negedge CLK);
    ACC = 1'b1;
    drive(1'b1, 24'hFFFFFF, 24'd1, 1'b1, 1'b1);
    @(negedge CLK);
    drive(1'b1, 24'd2, 24'd3, 1'b0, 1'b1);
    @(negedge CLK);
    ACC = 1'b0;
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    check("acc_z0", Z, 48'd100);
    @(negedge CLK);
    check("acc_z1", Z, 48'd99);
    @(negedge CLK);
    check("acc_z2", Z, 48'd105);
    @(negedge CLK);
`endif

    // Random traffic against the reference model, in order.
    for (int n = 0; n < 600; n++) begin
      r = $urandom;
      drive(r[0] | r[1], 24'($urandom), 24'($urandom), r[2], r[3] | r[4]);
      if (O_VALID && O_READY) begin
        if (q.size() == 0) check_bit("rand_spurious", O_VALID, 1'b0);
        else               check("rand_z", Z, q.pop_front());
      end
      if (I_VALID && I_READY) q.push_back(model(X, Y, TC));
      @(negedge CLK);
    end
    for (int n = 0; n < 20; n++) begin
      drive(1'b0, '0, '0, 1'b0, 1'b1);
      if (O_VALID) begin
        if (q.size() == 0) check_bit("rand_spurious", O_VALID, 1'b0);
        else               check("rand_z", Z, q.pop_front());
      end
      @(negedge CLK);
    end
    check("rand_drain_left", W'(q.size()), 48'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/r8b_mbe_pipe.md
R8B_MBE_PIPE -- requirements
Module: r8b_mbe_pipe

Interface
REQ-001 SHALL have parameter N, default 24: operand width in bits, legal range 6..64.
REQ-002 SHALL have parameter PIPE_STAGES, default 3: register stages from accepted operands to result, legal range 1..4.
REQ-003 SHALL have port CLK  input  1  single clock; all state rising-edge triggered.
REQ-004 SHALL have port RST_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port I_VALID  input  1  operands X, Y, TC valid this cycle.
REQ-006 SHALL have port I_READY  output  1  block accepts operands this cycle.
REQ-007 SHALL have port X  input  N  multiplicand.
REQ-008 SHALL have port Y  input  N  multiplier.
REQ-009 SHALL have port TC  input  1  1 = operands two's complement, 0 = unsigned; sampled with X, Y.
REQ-010 SHALL have port O_VALID  output  1  Z holds a valid result.
REQ-011 SHALL have port O_READY  input  1  downstream consumes Z this cycle.
REQ-012 SHALL have port Z  output  2N  exact product (or accumulator, see REQ-027).

Function
REQ-013 SHALL recode Y radix-8 modified Booth (overlapping 4-bit windows, digits -4..+4), Y extended by one bit (sign if TC=1, zero if TC=0), padded to a multiple of 3.
REQ-014 SHALL precompute 3X once per operation; partial products ±0, ±X, ±2X, ±3X, ±4X, X extended as Y.
REQ-015 SHALL produce Z equal to X*Y modulo 2^(2N), interpreted per TC; result always exact (fits 2N bits).
REQ-016 SHALL accept an operation when I_VALID and I_READY are both 1 at a rising edge.
REQ-017 SHALL drive I_READY = !O_VALID || O_READY (whole pipeline advances together).
REQ-018 SHALL assert O_VALID exactly PIPE_STAGES advancing cycles after acceptance; with O_READY tied 1, latency = PIPE_STAGES cycles.
REQ-019 SHALL freeze all stages, Z and O_VALID while O_VALID=1 and O_READY=0; Z stable, no operation lost or duplicated.
REQ-020 SHALL carry a valid bit per stage; cycles with I_VALID=0 propagate as bubbles, O_VALID=0 for them.
REQ-021 SHALL sustain throughput of one operation per cycle when O_READY=1.
REQ-022 SHALL leave Z at its last value when O_VALID deasserts (no forced zero).
REQ-023 SHALL partition stages: stage 1 recoding+3X, middle stages compression tree, final stage carry-propagate add; PIPE_STAGES=1 merges all.

Reset
REQ-024 SHALL on RST_n=0 asynchronously clear all stage valid bits, O_VALID=0, Z=0, accumulator=0.
REQ-025 SHALL drop in-flight operations on reset mid-operation; none emerge after release.
REQ-026 SHALL drive I_READY=1 during and after reset (O_VALID=0).

Configuration
REQ-027 With macro R8B_MBE_ACC_EN defined, SHALL add input ACC (1 bit, sampled with X, Y): result register holds A = ACC ? A + X*Y : X*Y, modulo 2^(2N), Z = A; update only on a valid result leaving the final stage.
REQ-028 Without R8B_MBE_ACC_EN, SHALL have no ACC port, no accumulator, Z = product per REQ-015.

Verification
REQ-029 N=24, PIPE_STAGES=3, O_READY=1: X=3, Y=5, TC=0 accepted cycle 0 -> O_VALID=1, Z=15 at cycle 3.
REQ-030 TC=0, X=Y=0xFFFFFF -> Z=0xFFFFFE000001; TC=1 same operands -> Z=1; TC=1 X=Y=0x800000 -> Z=0x400000000000.
REQ-031 Back-to-back 4 ops (2*3, 4*5, 6*7, 8*9, TC=0), O_READY=0 for cycles 3..6 -> I_READY=0 those cycles, Z=6 held, then 6, 20, 42, 72 in order, no loss.
REQ-032 RST_n pulsed low for 1 cycle with 2 ops in flight -> O_VALID=0, Z=0 immediately; no result emerges after release.
REQ-033 R8B_MBE_ACC_EN: ops (10*10, ACC=0), (TC=1 -1*1, ACC=1), (2*3, ACC=1) -> Z=100, 99, 105.
REQ-034 Random 10000 ops, random TC, random I_VALID/O_READY -> every Z matches reference model in order.
